// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between a CPU port and a host (loader /
// checker) port. A four-state FSM (IDLE -> CPU_ACC/HOST_ACC -> DONE -> IDLE)
// serves one access per three cycles. Arbitration happens only in IDLE.
//
// Handshake (both requester ports):
//   The requester raises req and holds req/we/addr/wdata stable until it sees
//   ack. The request is sampled on a rising clk edge while the FSM is in IDLE.
//   ack is a one-cycle pulse two edges after sampling. For reads, rdata is
//   valid together with ack and holds until the next read on that port
//   completes. Dropping req after the grant does not cancel the access.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   CPUstate[1:0]            CPU mode: 00 idle, 01 IN, 10 CHECK, 11 RUN
//   cpu_req/we/addr/wdata    CPU request (granted only in RUN)
//   cpu_ack/rdata            CPU completion pulse and read data
//   host_req/we/addr/wdata   host request
//   host_ack/rdata           host completion pulse and read data
//   mem_read/write           memory strobes, one cycle, never both high
//   mem_addr/wdata           memory address and write data
//   mem_rdata                memory read data, valid the cycle after mem_read
//   cpu_stall                cpu_req & ~cpu_ack
//   state_dbg[1:0]           current FSM state (IDLE=0 CPU_ACC=1 HOST_ACC=2 DONE=3)
//   starve_cnt               consecutive CPU grants taken while host waited
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        CPUstate,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cpu_stall,
    output logic [1:0]        state_dbg,
    output logic [SW-1:0]     starve_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        HOST_ACC = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t state;
    logic   grant_host;  // port that owns the access in flight
    logic   lat_we;      // we latched at grant

    logic run_mode;
    logic cpu_wins;

    assign run_mode = (CPUstate == 2'b11);
    // The CPU loses only when the host has waited through STARVE_MAX CPU grants.
    assign cpu_wins = run_mode && cpu_req && !(host_req && (starve_cnt >= STARVE_LIM));

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_host <= 1'b0;
            lat_we     <= 1'b0;
            starve_cnt <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= 1'b0;
            host_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_wins) begin
                        state      <= CPU_ACC;
                        grant_host <= 1'b0;
                        lat_we     <= cpu_we;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_wdata;
                        mem_read   <= ~cpu_we;
                        mem_write  <= cpu_we;
                        // cpu_wins with host_req set implies starve_cnt is
                        // below the limit, so the increment cannot overshoot.
                        if (host_req) starve_cnt <= starve_cnt + 1'b1;
                        else          starve_cnt <= '0;
                    end else if (host_req) begin
                        state      <= HOST_ACC;
                        grant_host <= 1'b1;
                        lat_we     <= host_we;
                        mem_addr   <= host_addr;
                        mem_wdata  <= host_wdata;
                        mem_read   <= ~host_we;
                        mem_write  <= host_we;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end

                // The strobe was issued on entry; memory read data arrives
                // during DONE.
                CPU_ACC, HOST_ACC: begin
                    state <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                    if (grant_host) begin
                        host_ack <= 1'b1;
                        if (!lat_we) host_rdata <= mem_rdata;
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!lat_we) cpu_rdata <= mem_rdata;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter: a cycle table for a CPU read in RUN and a
// host write in IN mode, followed by hand-written sequences for starvation
// rotation, simultaneous requests, reset during an access and a mode change
// during a host access. A small memory array answers mem_read one cycle later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int SW     = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        cpu_state;
    logic              cpu_req, cpu_we, host_req, host_we;
    logic [ADDR_W-1:0] cpu_addr, host_addr;
    logic [DATA_W-1:0] cpu_wdata, host_wdata;
    logic              cpu_ack, host_ack, mem_read, mem_write, cpu_stall;
    logic [DATA_W-1:0] cpu_rdata, host_rdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        state_dbg;
    logic [SW-1:0]     starve_cnt;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .CPUstate(cpu_state),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall),
        .state_dbg(state_dbg), .starve_cnt(starve_cnt)
    );

    // ---------------- memory model ----------------
    logic [DATA_W-1:0] mem_model [0:255];
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem_model[mem_addr[7:0]];
        if (mem_write) mem_model[mem_addr[7:0]] = mem_wdata;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cs,
                         input logic creq, input logic cwe, input logic [15:0] caddr, input logic [7:0] cwd,
                         input logic hreq, input logic hwe, input logic [15:0] haddr, input logic [7:0] hwd);
        cpu_state  = cs;
        cpu_req    = creq;  cpu_we  = cwe;  cpu_addr  = caddr; cpu_wdata  = cwd;
        host_req   = hreq;  host_we = hwe;  host_addr = haddr; host_wdata = hwd;
    endtask

    typedef struct {
        logic [1:0]  cs;
        logic        creq, cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        hreq, hwe;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic [1:0]  st;
        logic        rd, wr;
        logic [15:0] ma;
        logic [7:0]  mwd;
        logic        cack, hack, stall;
        logic [7:0]  crd, hrd;
    } vec_t;

    vec_t vecs [9];

    // watchdog: the bench is fixed-length, this only guards against a hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_model[8'h10] = 8'hA5;
        mem_model[8'h20] = 8'h5A;
        mem_model[8'h30] = 8'hC3;

        //            cs    req we addr     wd     hreq hwe haddr    hwd    | st rd wr ma       mwd    ca ha stl crd    hrd
        vecs[0] = '{2'b11, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 16'h0010, 8'h00, 0, 0, 1, 8'h00, 8'h00};
        vecs[1] = '{2'b11, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 16'h0010, 8'h00, 0, 0, 1, 8'h00, 8'h00};
        vecs[2] = '{2'b11, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 16'h0010, 8'h00, 1, 0, 0, 8'hA5, 8'h00};
        vecs[3] = '{2'b11, 0, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 16'h0010, 8'h00, 0, 0, 0, 8'hA5, 8'h00};
        vecs[4] = '{2'b01, 1, 0, 16'h0020, 8'h00, 1, 1, 16'h0100, 8'h3C, 2'd2, 0, 1, 16'h0100, 8'h3C, 0, 0, 1, 8'hA5, 8'h00};
        vecs[5] = '{2'b01, 1, 0, 16'h0020, 8'h00, 1, 1, 16'h0100, 8'h3C, 2'd3, 0, 0, 16'h0100, 8'h3C, 0, 0, 1, 8'hA5, 8'h00};
        vecs[6] = '{2'b01, 1, 0, 16'h0020, 8'h00, 1, 1, 16'h0100, 8'h3C, 2'd0, 0, 0, 16'h0100, 8'h3C, 0, 1, 1, 8'hA5, 8'h00};
        vecs[7] = '{2'b01, 1, 0, 16'h0020, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 16'h0100, 8'h3C, 0, 0, 1, 8'hA5, 8'h00};
        vecs[8] = '{2'b01, 1, 0, 16'h0020, 8'h00, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 16'h0100, 8'h3C, 0, 0, 1, 8'hA5, 8'h00};

        // ---------------- reset ----------------
        drive(2'b00, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("rst state",      state_dbg,  2'd0);
        chk("rst starve",     starve_cnt, 0);
        chk("rst mem_read",   mem_read,   0);
        chk("rst mem_write",  mem_write,  0);
        chk("rst mem_addr",   mem_addr,   0);
        chk("rst mem_wdata",  mem_wdata,  0);
        chk("rst acks",       {cpu_ack, host_ack}, 0);
        chk("rst rdata",      {cpu_rdata, host_rdata}, 0);
        rst = 1'b1;

        // ---------------- table: CPU read in RUN, host write in IN ----------------
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].cs, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
            tick();
            chk($sformatf("v%0d state", i),      state_dbg,  vecs[i].st);
            chk($sformatf("v%0d mem_read", i),   mem_read,   vecs[i].rd);
            chk($sformatf("v%0d mem_write", i),  mem_write,  vecs[i].wr);
            chk($sformatf("v%0d mem_addr", i),   mem_addr,   vecs[i].ma);
            chk($sformatf("v%0d mem_wdata", i),  mem_wdata,  vecs[i].mwd);
            chk($sformatf("v%0d cpu_ack", i),    cpu_ack,    vecs[i].cack);
            chk($sformatf("v%0d host_ack", i),   host_ack,   vecs[i].hack);
            chk($sformatf("v%0d cpu_stall", i),  cpu_stall,  vecs[i].stall);
            chk($sformatf("v%0d cpu_rdata", i),  cpu_rdata,  vecs[i].crd);
            chk($sformatf("v%0d host_rdata", i), host_rdata, vecs[i].hrd);
        end

        // ---------------- starvation rotation: 4 CPU grants then 1 host ----------------
        drive(2'b11, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0100, 8'h00);
        for (int k = 0; k < 10; k++) begin
            logic exp_host;
            exp_host = (k % 5 == 4);
            tick();
            chk($sformatf("rot%0d grant", k),  state_dbg,  exp_host ? 2'd2 : 2'd1);
            chk($sformatf("rot%0d starve", k), starve_cnt, exp_host ? 0 : (k % 5) + 1);
            chk($sformatf("rot%0d mem_read", k), mem_read, 1);
            tick();
            chk($sformatf("rot%0d done", k), state_dbg, 2'd3);
            tick();
            chk($sformatf("rot%0d acks", k), {cpu_ack, host_ack}, exp_host ? 2'b01 : 2'b10);
            if (exp_host) chk($sformatf("rot%0d host_rdata", k), host_rdata, 8'h3C);
            else          chk($sformatf("rot%0d cpu_rdata", k),  cpu_rdata,  8'hA5);
        end
        drive(2'b11, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        tick();
        chk("rot idle starve", starve_cnt, 0);

        // ---------------- simultaneous first requests ----------------
        drive(2'b11, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0030, 8'h00);
        tick();
        chk("sim first grant", state_dbg, 2'd1);
        chk("sim starve", starve_cnt, 1);
        tick();
        tick();
        chk("sim cpu_ack", {cpu_ack, host_ack}, 2'b10);
        chk("sim cpu_rdata", cpu_rdata, 8'h5A);
        cpu_req = 1'b0;
        tick();
        chk("sim second grant", state_dbg, 2'd2);
        chk("sim second addr", mem_addr, 16'h0030);
        chk("sim starve clr", starve_cnt, 0);
        tick();
        tick();
        chk("sim host_ack", {cpu_ack, host_ack}, 2'b01);
        chk("sim host_rdata", host_rdata, 8'hC3);
        chk("sim cpu_rdata kept", cpu_rdata, 8'h5A);
        host_req = 1'b0;
        tick();

        // ---------------- reset during CPU_ACC ----------------
        drive(2'b11, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0);
        tick();
        chk("rstacc grant", {state_dbg, mem_read}, {2'd1, 1'b1});
        rst = 1'b0;
        #1;
        chk("rstacc async mem_read", mem_read, 0);
        chk("rstacc async state", state_dbg, 2'd0);
        chk("rstacc async rdata", cpu_rdata, 8'h00);
        tick();
        chk("rstacc held ack", cpu_ack, 0);
        chk("rstacc held state", state_dbg, 2'd0);
        rst = 1'b1;
        tick();
        chk("rstacc regrant", {state_dbg, mem_read}, {2'd1, 1'b1});
        tick();
        chk("rstacc no early ack", cpu_ack, 0);
        tick();
        chk("rstacc ack", cpu_ack, 1);
        chk("rstacc rdata", cpu_rdata, 8'hA5);
        cpu_req = 1'b0;
        tick();

        // ---------------- mode change during HOST_ACC ----------------
        drive(2'b11, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0030, 8'h00);
        tick();
        chk("mode host grant", state_dbg, 2'd2);
        cpu_state = 2'b10;
        cpu_req   = 1'b1;
        cpu_addr  = 16'h0010;
        tick();
        chk("mode done", state_dbg, 2'd3);
        tick();
        chk("mode host_ack", host_ack, 1);
        chk("mode host_rdata", host_rdata, 8'hC3);
        host_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("mode%0d idle", j), state_dbg, 2'd0);
            chk($sformatf("mode%0d no ack", j), {cpu_ack, mem_read}, 2'b00);
            chk($sformatf("mode%0d stall", j), cpu_stall, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 Parameter STARVE_MAX, default 4, the number of consecutive CPU grants after which a waiting host request takes priority.
REQ-004 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 CPUstate  input  2  CPU mode: 00 idle, 01 IN, 10 CHECK, 11 RUN.
REQ-007 cpu_req / cpu_we  input  1 / 1  CPU access request and write-select (1 = write).
REQ-008 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU address and write data.
REQ-009 cpu_ack / cpu_rdata  output  1 / DATA_W  one-cycle completion pulse and read data for the CPU.
REQ-010 host_req, host_we, host_addr, host_wdata, host_ack, host_rdata  same directions and widths as the cpu_* ports  loader/checker port.
REQ-011 mem_read / mem_write  output  1 / 1  memory strobes.
REQ-012 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_read.
REQ-014 cpu_stall  output  1  holds the CPU beat counter while a CPU request is pending and not yet acked.

Function
REQ-015 The FSM SHALL have the states IDLE, CPU_ACC, HOST_ACC and DONE.
- Encoding is free.
- Exactly one state is active at any time.
REQ-016 Arbitration SHALL occur only in IDLE; a request is sampled at the rising clk edge.
REQ-017 In RUN (11), priority SHALL go to the CPU, except when host_req=1 and starve_cnt>=STARVE_MAX; in that case HOST_ACC is entered.
REQ-018 In states other than RUN, only host_req SHALL be granted; cpu_req is ignored, gets no ack and keeps cpu_stall=1.
REQ-019 In CPU_ACC and HOST_ACC the block SHALL drive mem_addr and mem_wdata from the granted port, and assert mem_read=~we or mem_write=we, for exactly one cycle.
REQ-020 In DONE the block SHALL pulse the granted port's ack for one cycle and then return to IDLE.
- On a read, DONE also registers mem_rdata into that port's rdata.
- rdata holds its value until the next read on that port completes.
REQ-021 Latency SHALL be 2 cycles from request sampling to ack.
- Back-to-back throughput is one access per 3 cycles (IDLE, ACC, DONE).
REQ-022 A requester SHALL hold req, we, addr and wdata stable until ack.
- The block registers addr, wdata and we on grant.
- A req dropped after grant does not cancel the access; ack still pulses.
REQ-023 starve_cnt (3 bits minimum) SHALL update as follows:
- increments on each CPU grant while host_req=1;
- clears on each host grant, or when host_req=0 at the arbitration point;
- saturates at STARVE_MAX.
REQ-024 cpu_stall SHALL equal cpu_req & ~cpu_ack, combinationally.
REQ-025 When both requests arrive in the same cycle with starve_cnt<STARVE_MAX in RUN, the CPU SHALL be granted.
REQ-026 A change of CPUstate during CPU_ACC, HOST_ACC or DONE SHALL NOT abort the access; the new mode applies at the next IDLE arbitration.
REQ-027 mem_read and mem_write SHALL never both be 1, and SHALL both be 0 in IDLE and DONE.

Reset
REQ-028 While rst=0 the block SHALL immediately force the following, independent of clk:
- state=IDLE and starve_cnt=0;
- mem_read=mem_write=0, cpu_ack=host_ack=0;
- mem_addr=0, mem_wdata=0, cpu_rdata=0, host_rdata=0.
REQ-029 Reset asserted mid-access SHALL abandon the access with no ack.
- The first arbitration after release is at the first rising clk edge with rst=1.

Verification
REQ-030 RUN, CPU read of addr 0x0010 with mem_rdata=0xA5 -> mem_read=1 and mem_addr=0x0010 one cycle after sampling, then cpu_ack pulse with cpu_rdata=0xA5; the ack rises 2 cycles after sampling.
REQ-031 IN mode, host write of 0x3C to 0x0100 with cpu_req also high -> mem_write=1, mem_wdata=0x3C, host_ack pulse; no cpu_ack; cpu_stall=1 throughout.
REQ-032 RUN, cpu_req and host_req held continuously -> 4 CPU grants, then 1 host grant, repeating; starve_cnt returns to 0 after each host grant.
REQ-033 Simultaneous first requests in RUN -> CPU granted first, host granted at the next IDLE; rdata of each port is correct and not swapped.
REQ-034 rst pulsed low during CPU_ACC -> mem_read drops in the same cycle, no cpu_ack; after release, the held cpu_req is re-served normally.
REQ-035 CPUstate switched from RUN to CHECK during HOST_ACC -> the access completes with host_ack; a subsequent cpu_req is not granted.
